// File: rtl/prog_counter_n.sv
// Programmable up/down counter with stop-or-wrap terminal handling and a terminal-count pulse.
// Define PROG_CNT_BCD_EN to add the registered binary-to-BCD output bcd_out.
module prog_counter_n #(
    parameter int WIDTH      = 7,
    parameter int MAX_VAL    = 99,
    parameter int BCD_DIGITS = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic             en,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] max_count,
    output logic [WIDTH-1:0] count_out,
    output logic             done,
    output logic             tc,
    output logic [1:0]       fsm_state
`ifdef PROG_CNT_BCD_EN
    ,
    output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_LIM = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] lim_q;
    logic             dir_q;
    logic             wrap_q;

    logic [WIDTH-1:0] lim_in;
    logic [WIDTH-1:0] start_in;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;
    logic             at_term;
    logic             step_hits_term;

    // Values seen on the program inputs, used only while run is low.
    always_comb begin
        lim_in   = (max_count > MAX_LIM) ? MAX_LIM : max_count;
        start_in = dir ? lim_in : '0;
    end

    // Values derived from the latched configuration, used while counting.
    always_comb begin
        start_val      = dir_q ? lim_q : '0;
        term_val       = dir_q ? '0 : lim_q;
        step_val       = dir_q ? (count_out - ONE) : (count_out + ONE);
        at_term        = (count_out == term_val);
        step_hits_term = (step_val == term_val);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            lim_q     <= '0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
            count_out <= '0;
            done      <= 1'b0;
            tc        <= 1'b0;
        end else if (!run) begin
            state     <= IDLE;
            lim_q     <= lim_in;
            dir_q     <= dir;
            wrap_q    <= wrap;
            count_out <= start_in;
            done      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    if (lim_q == '0) begin
                        // Start equals terminal: flag on entry, then on every enabled edge.
                        tc <= (state == IDLE) || en;
                        if (!wrap_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end else begin
                        state <= COUNT;
                        if (en) begin
                            if (at_term) begin
                                count_out <= start_val;
                                tc        <= 1'b0;
                            end else begin
                                count_out <= step_val;
                                tc        <= step_hits_term;
                                if (step_hits_term && !wrap_q) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end else begin
                            tc <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    tc <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    tc    <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

`ifdef PROG_CNT_BCD_EN
    // Enough internal digits to hold any WIDTH-bit value; excess digits drive saturation.
    localparam int FULL_DIGITS = ((WIDTH + 2) / 3 > BCD_DIGITS) ? (WIDTH + 2) / 3 : BCD_DIGITS;

    logic [4*FULL_DIGITS-1:0] bcd_acc;
    logic [4*BCD_DIGITS-1:0]  bcd_next;
    logic                     bcd_ovf;

    always_comb begin
        bcd_acc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < FULL_DIGITS; d++) begin
                if (bcd_acc[4*d +: 4] >= 4'd5) begin
                    bcd_acc[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
                end
            end
            bcd_acc = {bcd_acc[4*FULL_DIGITS-2:0], count_out[i]};
        end
        bcd_ovf = 1'b0;
        for (int d = BCD_DIGITS; d < FULL_DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] != 4'd0) begin
                bcd_ovf = 1'b1;
            end
        end
        bcd_next = bcd_ovf ? {BCD_DIGITS{4'h9}} : bcd_acc[4*BCD_DIGITS-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bcd_out <= '0;
        end else begin
            bcd_out <= bcd_next;
        end
    end
`else
    // Binary-only build: no converter and no bcd_out port.
`endif

endmodule

// File: doc/prog_counter_n.md
# prog_counter_n

Parametrised programmable counter, the successor to the fixed 7-bit, 0–99 programmable counter. It counts up from zero or down from a programmed limit, under a per-cycle enable. It either stops at the terminal value or wraps, and flags terminal count. The clock is never gated: all control is by synchronous enables on the single `CLK` domain. It feeds the display path, optionally through a built-in registered BCD output.

## Interface
- `WIDTH`, default 7: counter and limit width in bits.
- `MAX_VAL`, default 99: hard ceiling for the limit. Must be at most 2^WIDTH−1.
- `BCD_DIGITS`, default 2: number of BCD digits on `bcd_out`. Used only with `PROG_CNT_BCD_EN`.
- `CLK`, in, 1: single clock, rising edge.
- `RST_N`, in, 1: reset, asynchronous and active-low.
- `run`, in, 1: 0 means idle/program, 1 means count.
- `en`, in, 1: count-step enable, sampled while counting.
- `dir`, in, 1: 0 counts up, 1 counts down. Latched in IDLE.
- `wrap`, in, 1: 0 stops at terminal, 1 reloads and continues. Latched in IDLE.
- `max_count`, in, WIDTH: programmed limit. Latched in IDLE.
- `count_out`, out, WIDTH: current count, registered.
- `done`, out, 1: level; high while in DONE.
- `tc`, out, 1: one-cycle pulse on the edge where `count_out` is loaded with the terminal value.
- `bcd_out`, out, 4*BCD_DIGITS: registered BCD of `count_out`. Present only with `PROG_CNT_BCD_EN`.

## Operation
- Limit: `lim = (max_count > MAX_VAL) ? MAX_VAL : max_count`.
- Start and terminal values:
  - Up: start = 0, term = `lim`.
  - Down: start = `lim`, term = 0.
- States: IDLE, COUNT, DONE.
- IDLE (any edge with `run`=0, from any state):
  - Latch `lim`, `dir`, `wrap`.
  - `count_out` <= start, computed from the current inputs.
  - `done` <= 0, `tc` <= 0.
- IDLE -> COUNT on the first edge with `run`=1.
  - If start == term on that edge (limit 0): `tc` <= 1.
  - Limit 0 with `wrap`=0: go to DONE, `done` <= 1, no `en` needed.
  - Limit 0 with `wrap`=1: stay in COUNT, pulse `tc` on every `en` edge, count held at 0.
- COUNT with `en`=1:
  - `count_out` steps ±1.
  - If the new value == term: `tc` <= 1. If `wrap`=0, also go to DONE with `done` <= 1.
  - If `wrap`=1 and `count_out` == term: next `en` edge loads start, no `tc`.
- COUNT with `en`=0: hold everything, `tc` <= 0.
- DONE: `count_out` holds term, `done` stays 1, `en` ignored. Exit only via `run`=0.
- While `run`=1, changes on `max_count`, `dir` and `wrap` have no effect.
- Arithmetic is modulo 2^WIDTH internally. The count never leaves [0, lim], so no overflow is reachable.

## Timing
- Reset (asynchronous assert, synchronous release on the next `CLK` edge):
  - State IDLE.
  - `count_out` = 0, `done` = 0, `tc` = 0, latched limit = 0.
  - `bcd_out` = 0.
- `run` rising: the first step occurs on the first edge with `run`=1 and `en`=1. That can be the same edge as the IDLE -> COUNT transition, which then both steps and transitions.
- `tc` and `done` rise on the same edge that loads term into `count_out`. There is zero lag relative to the count.
- `run` falling mid-count or in DONE: on the next edge, the count reloads start and `done`/`tc` clear.
- Reset asserted mid-operation: outputs take their reset values immediately, with no clock needed.
- `bcd_out` lags `count_out` by exactly one cycle.

## Configuration
- `PROG_CNT_BCD_EN` defined:
  - Adds the `bcd_out` port.
  - Adds a registered binary-to-BCD stage: combinational double-dabble of `count_out`, then one flop stage.
  - Digits are little-endian: `bcd_out[3:0]` = ones.
  - Values ≥ 10^BCD_DIGITS saturate to all nines.
- Not defined: no `bcd_out` port and no converter logic. All other behaviour is identical.

## Test plan
- Up, stop mode: reset, `max_count`=5, `dir`=0, `wrap`=0, `run`=1, `en`=1 constant.
  - Count goes 1,2,3,4,5 on successive edges.
  - `tc` and `done` rise with the 5. `tc` is low the next cycle, `done` stays high and the count holds at 5.
- Down, wrap mode with gapped enable: `max_count`=3, `dir`=1, `wrap`=1, `en` toggling 1/0.
  - Count goes 3,2,1,0,3,2… advancing only on `en`=1 edges.
  - `tc` pulses each time 0 is loaded. `done` stays 0.
- Clamp: `max_count`=120 with defaults.
  - The up count stops at 99 with `done`=1.
  - Changing `max_count` to 10 mid-run has no effect.
- Abort and limit zero:
  - `run` dropped at count 40: the next edge gives count 0, `done` 0.
  - Restart with `max_count`=0, `wrap`=0: the first `run` edge gives `tc`=1 and `done`=1 at count 0.
- Async reset: assert `RST_N`=0 between edges while at count 7. All outputs go to 0 immediately, with no clock edge.
- `PROG_CNT_BCD_EN`: count to 57. `bcd_out` = 8'h57 one cycle after `count_out` = 57.
